// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator: counters, pixel request, sync/blank/colour pipeline.
// Latency: counter state at cycle t reaches the vga_* pins at t+2; frame_start and pix_req are at t.
// Backpressure: none. The pixel source must return pix_rgb exactly one cycle after pix_req.
//
// Ports:
//   clk, nrst            pixel clock, asynchronous active-low reset
//   enable               level-sensitive run request; stopping always finishes the current frame
//   pix_req/pix_x/pix_y  pixel request and its coordinates (coordinates driven at all times)
//   pix_rgb              {r,g,b} returned by the source one cycle after pix_req
//   frame_start          one-cycle pulse at hcnt=0, vcnt=0 while running
//   running              high while the raster is counting (RUN or STOPPING)
//   vga_hs/vga_vs        active-low syncs
//   vga_blank_n          high on visible pixels
//   vga_sync_n           tied low
//   vga_r/vga_g/vga_b    colour, forced to zero outside the visible area
module vga_timing_ctrl #(
    parameter int HDISP  = 640,
    parameter int HFP    = 16,
    parameter int HPULSE = 96,
    parameter int HBP    = 48,
    parameter int VDISP  = 480,
    parameter int VFP    = 10,
    parameter int VPULSE = 2,
    parameter int VBP    = 33
) (
    input  logic                                          clk,
    input  logic                                          nrst,
    input  logic                                          enable,
    output logic                                          pix_req,
    output logic [$clog2(HDISP+HFP+HPULSE+HBP)-1:0]       pix_x,
    output logic [$clog2(VDISP+VFP+VPULSE+VBP)-1:0]       pix_y,
    input  logic [23:0]                                   pix_rgb,
    output logic                                          frame_start,
    output logic                                          running,
    output logic                                          vga_hs,
    output logic                                          vga_vs,
    output logic                                          vga_blank_n,
    output logic                                          vga_sync_n,
    output logic [7:0]                                    vga_r,
    output logic [7:0]                                    vga_g,
    output logic [7:0]                                    vga_b
);

    localparam int HTOTAL = HDISP + HFP + HPULSE + HBP;
    localparam int VTOTAL = VDISP + VFP + VPULSE + VBP;
    localparam int HW     = $clog2(HTOTAL);
    localparam int VW     = $clog2(VTOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(HTOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(VTOTAL - 1);

    // Region edges compared as int so a zero-width back porch cannot overflow the counter width.
    localparam int HS_BEG = HDISP + HFP;
    localparam int HS_END = HDISP + HFP + HPULSE;
    localparam int VS_BEG = VDISP + VFP;
    localparam int VS_END = VDISP + VFP + VPULSE;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;

    logic          active;
    logic          h_last, v_last, frame_last;
    logic          h_vis, v_vis, h_sync, v_sync;

    // Stage 1 and stage 2 pipeline registers.
    logic          hs_d1_q, vs_d1_q, vis_d1_q;
    logic          vga_hs_q, vga_vs_q, vga_blank_n_q;
    logic [23:0]   vga_rgb_q;

    assign active     = (state_q != ST_IDLE);
    assign h_last     = (hcnt_q == H_LAST);
    assign v_last     = (vcnt_q == V_LAST);
    assign frame_last = h_last && v_last;

    assign h_vis  = (int'(hcnt_q) < HDISP);
    assign v_vis  = (int'(vcnt_q) < VDISP);
    assign h_sync = (int'(hcnt_q) >= HS_BEG) && (int'(hcnt_q) < HS_END);
    assign v_sync = (int'(vcnt_q) >= VS_BEG) && (int'(vcnt_q) < VS_END);

    // A run request seen in STOPPING wins over the end of frame, so the
    // raster simply keeps going without a gap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enable) state_d = ST_RUN;
            ST_RUN:  if (!enable) state_d = ST_STOP;
            ST_STOP: begin
                if (enable) begin
                    state_d = ST_RUN;
                end else if (frame_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counters sit at 0 in IDLE so the first RUN cycle is always (0,0).
    // Leaving STOPPING happens on the wrap cycle, so the counters land on 0 anyway.
    always_comb begin
        hcnt_d = '0;
        vcnt_d = '0;
        if (active) begin
            if (h_last) begin
                hcnt_d = '0;
                vcnt_d = v_last ? '0 : vcnt_q + VW'(1);
            end else begin
                hcnt_d = hcnt_q + HW'(1);
                vcnt_d = vcnt_q;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
        end
    end

    // Stage 0: request and coordinates straight from the counters.
    assign pix_req     = active && h_vis && v_vis;
    assign pix_x       = hcnt_q;
    assign pix_y       = vcnt_q;
    assign frame_start = (state_q == ST_RUN) && (hcnt_q == '0) && (vcnt_q == '0);
    assign running     = active;

    // Stage 1 delays the timing flags by one cycle to meet pix_rgb;
    // stage 2 registers the pins with colour masked outside the visible area.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hs_d1_q       <= 1'b0;
            vs_d1_q       <= 1'b0;
            vis_d1_q      <= 1'b0;
            vga_hs_q      <= 1'b1;
            vga_vs_q      <= 1'b1;
            vga_blank_n_q <= 1'b0;
            vga_rgb_q     <= '0;
        end else begin
            hs_d1_q       <= active && h_sync;
            vs_d1_q       <= active && v_sync;
            vis_d1_q      <= pix_req;
            vga_hs_q      <= ~hs_d1_q;
            vga_vs_q      <= ~vs_d1_q;
            vga_blank_n_q <= vis_d1_q;
            vga_rgb_q     <= vis_d1_q ? pix_rgb : 24'h0;
        end
    end

    assign vga_hs      = vga_hs_q;
    assign vga_vs      = vga_vs_q;
    assign vga_blank_n = vga_blank_n_q;
    assign vga_sync_n  = 1'b0;
    assign vga_r       = vga_rgb_q[23:16];
    assign vga_g       = vga_rgb_q[15:8];
    assign vga_b       = vga_rgb_q[7:0];

endmodule
